// File: rtl/rob_defs.sv
// Shared definitions for the reorder buffer: entry type encodings, field widths and default depth.
package rob_defs;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int DEST_W        = 5;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_BRANCH = 2'd1,
        ROB_TYPE_STORE  = 2'd2,
        ROB_TYPE_RSVD   = 2'd3
    } rob_type_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy tracking for the reorder buffer; pointers wrap modulo depth,
// and a flush returns everything to the empty state.
module rob_ptr_ctrl #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 i_issue,
    input  logic                 i_commit,
    input  logic                 i_flush,
    output logic [ROB_WIDTH-1:0] o_head,
    output logic [ROB_WIDTH-1:0] o_tail,
    output logic                 o_full
);

    localparam logic [ROB_WIDTH:0] DEPTH = {1'b1, {ROB_WIDTH{1'b0}}};

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_issue)  r_tail <= r_tail + 1'b1;
            if (i_commit) r_head <= r_head + 1'b1;
            case ({i_issue, i_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_tail = r_tail;
    assign o_full = (r_count == DEPTH);

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at issue, captures CDB results, retires one entry per cycle.
// Define ROB_BYPASS_EN to let the operand query see the live CDB in the same cycle.
module reorder_buffer
    import rob_defs::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 robAddValid,
    input  logic [1:0]           robAddType,
    input  logic [DEST_W-1:0]    robAddDest,
    output logic [ROB_WIDTH-1:0] robAddId,
    output logic                 robFull,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbRobId,
    input  logic [DATA_W-1:0]    cdbValue,
    input  logic                 cdbMispredict,
    input  logic [DATA_W-1:0]    cdbTarget,
    output logic                 regUpdateValid,
    output logic [DEST_W-1:0]    regUpdateDest,
    output logic [DATA_W-1:0]    regUpdateValue,
    output logic [ROB_WIDTH-1:0] regUpdateRobId,
    input  logic [ROB_WIDTH-1:0] robRs1Dep,
    output logic                 robRs1Ready,
    output logic [DATA_W-1:0]    robRs1Value,
    input  logic [ROB_WIDTH-1:0] robRs2Dep,
    output logic                 robRs2Ready,
    output logic [DATA_W-1:0]    robRs2Value,
    output logic                 storeCommit,
    output logic [ROB_WIDTH-1:0] storeRobId,
    output logic                 flushOut,
    output logic [DATA_W-1:0]    flushPc
);

    localparam int DEPTH = 2 ** ROB_WIDTH;

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_misp;
    logic [1:0]        r_type   [DEPTH];
    logic [DEST_W-1:0] r_dest   [DEPTH];
    logic [DATA_W-1:0] r_value  [DEPTH];
    logic [DATA_W-1:0] r_target [DEPTH];

    logic [ROB_WIDTH-1:0] w_head;
    logic [ROB_WIDTH-1:0] w_tail;
    logic                 w_full;
    logic                 w_commit;
    logic                 w_flush;
    logic                 w_issue;
    logic                 w_cdb;
    logic [1:0]           w_head_type;

    assign w_head_type = r_type[w_head];
    assign w_commit    = r_busy[w_head] && r_ready[w_head];
    assign w_flush     = w_commit && (w_head_type == ROB_TYPE_BRANCH) && r_misp[w_head];
    assign w_issue     = robAddValid && !w_full && !w_flush;
    // A result aimed at the entry retiring this cycle must not resurrect its ready bit.
    assign w_cdb       = cdbValid && r_busy[cdbRobId] && !w_flush &&
                         !(w_commit && (cdbRobId == w_head));

    rob_ptr_ctrl #(.ROB_WIDTH(ROB_WIDTH)) u_ptr (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .i_issue  (w_issue),
        .i_commit (w_commit),
        .i_flush  (w_flush),
        .o_head   (w_head),
        .o_tail   (w_tail),
        .o_full   (w_full)
    );

    assign robAddId = w_tail;
    assign robFull  = w_full;

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_misp  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i]   <= '0;
                r_dest[i]   <= '0;
                r_value[i]  <= '0;
                r_target[i] <= '0;
            end
        end else if (w_flush) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_misp  <= '0;
        end else begin
            if (w_commit) begin
                r_busy[w_head]  <= 1'b0;
                r_ready[w_head] <= 1'b0;
            end
            if (w_cdb) begin
                r_ready[cdbRobId]  <= 1'b1;
                r_value[cdbRobId]  <= cdbValue;
                r_misp[cdbRobId]   <= cdbMispredict;
                r_target[cdbRobId] <= cdbTarget;
            end
            if (w_issue) begin
                r_busy[w_tail]  <= 1'b1;
                r_ready[w_tail] <= 1'b0;
                r_misp[w_tail]  <= 1'b0;
                r_type[w_tail]  <= robAddType;
                r_dest[w_tail]  <= robAddDest;
            end
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            regUpdateValid <= 1'b0;
            regUpdateDest  <= '0;
            regUpdateValue <= '0;
            regUpdateRobId <= '0;
            storeCommit    <= 1'b0;
            storeRobId     <= '0;
            flushOut       <= 1'b0;
            flushPc        <= '0;
        end else begin
            regUpdateValid <= 1'b0;
            storeCommit    <= 1'b0;
            flushOut       <= 1'b0;
            if (w_commit) begin
                case (w_head_type)
                    ROB_TYPE_STORE: begin
                        storeCommit <= 1'b1;
                        storeRobId  <= w_head;
                    end
                    ROB_TYPE_BRANCH: begin
                        if (r_misp[w_head]) begin
                            flushOut <= 1'b1;
                            flushPc  <= r_target[w_head];
                        end
                    end
                    default: begin
                        regUpdateValid <= 1'b1;
                        regUpdateDest  <= r_dest[w_head];
                        regUpdateValue <= r_value[w_head];
                        regUpdateRobId <= w_head;
                    end
                endcase
            end
        end
    end

    always_comb begin
        robRs1Ready = r_busy[robRs1Dep] && r_ready[robRs1Dep];
        robRs1Value = r_value[robRs1Dep];
        robRs2Ready = r_busy[robRs2Dep] && r_ready[robRs2Dep];
        robRs2Value = r_value[robRs2Dep];
`ifdef ROB_BYPASS_EN
        if (cdbValid && (cdbRobId == robRs1Dep)) begin
            robRs1Ready = 1'b1;
            robRs1Value = cdbValue;
        end
        if (cdbValid && (cdbRobId == robRs2Dep)) begin
            robRs2Ready = 1'b1;
            robRs2Value = cdbValue;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
    import rob_defs::*;

    localparam int W = 4;
    localparam int D = 16;

    logic          clockIn = 1'b0;
    logic          resetIn = 1'b0;
    logic          robAddValid = 1'b0;
    logic [1:0]    robAddType = '0;
    logic [4:0]    robAddDest = '0;
    logic [W-1:0]  robAddId;
    logic          robFull;
    logic          cdbValid = 1'b0;
    logic [W-1:0]  cdbRobId = '0;
    logic [31:0]   cdbValue = '0;
    logic          cdbMispredict = 1'b0;
    logic [31:0]   cdbTarget = '0;
    logic          regUpdateValid;
    logic [4:0]    regUpdateDest;
    logic [31:0]   regUpdateValue;
    logic [W-1:0]  regUpdateRobId;
    logic [W-1:0]  robRs1Dep = '0;
    logic          robRs1Ready;
    logic [31:0]   robRs1Value;
    logic [W-1:0]  robRs2Dep = '0;
    logic          robRs2Ready;
    logic [31:0]   robRs2Value;
    logic          storeCommit;
    logic [W-1:0]  storeRobId;
    logic          flushOut;
    logic [31:0]   flushPc;

    always #5 clockIn = ~clockIn;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clockIn(clockIn), .resetIn(resetIn),
        .robAddValid(robAddValid), .robAddType(robAddType), .robAddDest(robAddDest),
        .robAddId(robAddId), .robFull(robFull),
        .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue),
        .cdbMispredict(cdbMispredict), .cdbTarget(cdbTarget),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
        .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
        .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
        .storeCommit(storeCommit), .storeRobId(storeRobId),
        .flushOut(flushOut), .flushPc(flushPc)
    );

    typedef struct {
        int          id;
        logic [1:0]  typ;
        logic [4:0]  dest;
        bit          rdy;
        logic [31:0] val;
        bit          misp;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    int   n_checks;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void exp_query(input logic [W-1:0] dep, output logic rdy, output logic [31:0] v);
        rdy = 1'b0;
        v   = '0;
        foreach (q[i]) if (q[i].id == int'(dep) && q[i].rdy) begin
            rdy = 1'b1;
            v   = q[i].val;
        end
`ifdef ROB_BYPASS_EN
        if (cdbValid && cdbRobId == dep) begin
            rdy = 1'b1;
            v   = cdbValue;
        end
`endif
    endfunction

    task automatic idle();
        robAddValid   = 1'b0;
        cdbValid      = 1'b0;
        cdbMispredict = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        logic er;
        logic [31:0] ev;
        ent_t e;
        bit full, fl;
        logic x_rv, x_sc, x_fl;
        logic [4:0] x_dest;
        logic [31:0] x_val, x_pc;
        int x_rid, x_sid;
        #1;
        check("robFull", 32'(robFull), 32'(q.size() == D));
        check("robAddId", 32'(robAddId), 32'(m_tail));
        exp_query(robRs1Dep, er, ev);
        check("rs1Ready", 32'(robRs1Ready), 32'(er));
        if (er) check("rs1Value", robRs1Value, ev);
        exp_query(robRs2Dep, er, ev);
        check("rs2Ready", 32'(robRs2Ready), 32'(er));
        if (er) check("rs2Value", robRs2Value, ev);

        full = (q.size() == D);
        fl = 0; x_rv = 0; x_sc = 0; x_fl = 0;
        x_dest = '0; x_val = '0; x_pc = '0; x_rid = 0; x_sid = 0;
        if (q.size() > 0 && q[0].rdy) begin
            e = q.pop_front();
            case (e.typ)
                ROB_TYPE_STORE:  begin x_sc = 1; x_sid = e.id; end
                ROB_TYPE_BRANCH: if (e.misp) begin x_fl = 1; x_pc = e.tgt; fl = 1; end
                default:         begin x_rv = 1; x_dest = e.dest; x_val = e.val; x_rid = e.id; end
            endcase
        end
        if (fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (cdbValid) foreach (q[i]) if (q[i].id == int'(cdbRobId)) begin
                q[i].rdy  = 1;
                q[i].val  = cdbValue;
                q[i].misp = cdbMispredict;
                q[i].tgt  = cdbTarget;
            end
            if (robAddValid && !full) begin
                e = '{id: m_tail, typ: robAddType, dest: robAddDest, rdy: 0, val: '0, misp: 0, tgt: '0};
                q.push_back(e);
                m_tail = (m_tail + 1) % D;
            end
        end

        @(posedge clockIn);
        #1;
        check("regUpdateValid", 32'(regUpdateValid), 32'(x_rv));
        if (x_rv) begin
            check("regUpdateDest", 32'(regUpdateDest), 32'(x_dest));
            check("regUpdateValue", regUpdateValue, x_val);
            check("regUpdateRobId", 32'(regUpdateRobId), 32'(x_rid));
        end
        check("storeCommit", 32'(storeCommit), 32'(x_sc));
        if (x_sc) check("storeRobId", 32'(storeRobId), 32'(x_sid));
        check("flushOut", 32'(flushOut), 32'(x_fl));
        if (x_fl) check("flushPc", flushPc, x_pc);
        @(negedge clockIn);
    endtask

    // Asserts reset between clock edges and checks that everything clears immediately.
    task automatic do_reset();
        idle();
        robRs1Dep = '0;
        robRs2Dep = '0;
        resetIn = 1'b0;
        q.delete();
        m_tail = 0;
        #2;
        check("rst_regUpdateValid", 32'(regUpdateValid), 32'd0);
        check("rst_regUpdateDest", 32'(regUpdateDest), 32'd0);
        check("rst_regUpdateValue", regUpdateValue, 32'd0);
        check("rst_regUpdateRobId", 32'(regUpdateRobId), 32'd0);
        check("rst_storeCommit", 32'(storeCommit), 32'd0);
        check("rst_storeRobId", 32'(storeRobId), 32'd0);
        check("rst_flushOut", 32'(flushOut), 32'd0);
        check("rst_flushPc", flushPc, 32'd0);
        check("rst_robFull", 32'(robFull), 32'd0);
        check("rst_robAddId", 32'(robAddId), 32'd0);
        check("rst_rs1Ready", 32'(robRs1Ready), 32'd0);
        check("rst_rs2Ready", 32'(robRs2Ready), 32'd0);
        @(negedge clockIn);
        resetIn = 1'b1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] d);
        robAddValid = 1'b1;
        robAddType  = t;
        robAddDest  = d;
    endtask

    task automatic cdb(input int id, input logic [31:0] v, input logic m, input logic [31:0] tg);
        cdbValid      = 1'b1;
        cdbRobId      = W'(id);
        cdbValue      = v;
        cdbMispredict = m;
        cdbTarget     = tg;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_tail   = 0;

        // Basic REG issue, complete, commit
        do_reset();
        issue(ROB_TYPE_REG, 5'd5); cycle();
        idle(); cdb(0, 32'h1234, 0, 0); cycle();
        idle(); cycle();
        check("t1_regValid", 32'(regUpdateValid), 32'd1);
        check("t1_regDest", 32'(regUpdateDest), 32'd5);
        check("t1_regValue", regUpdateValue, 32'h1234);
        check("t1_regRobId", 32'(regUpdateRobId), 32'd0);

        // Fill to capacity, then an extra issue is dropped
        do_reset();
        for (int i = 0; i < D; i++) begin
            issue(ROB_TYPE_REG, 5'(i + 1)); cycle();
        end
        issue(ROB_TYPE_REG, 5'd31); cycle();
        idle(); #1;
        check("t2_full", 32'(robFull), 32'd1);
        check("t2_addId", 32'(robAddId), 32'd0);

        // Complete head while full and keep issuing; ordered drain afterwards
        issue(ROB_TYPE_REG, 5'd20); cdb(0, 32'hA0, 0, 0); cycle();
        idle(); issue(ROB_TYPE_REG, 5'd20); cycle();
        cycle();
        idle(); #1;
        check("t3_full_again", 32'(robFull), 32'd1);
        for (int i = D - 1; i >= 1; i--) begin
            cdb(i, 32'h100 + 32'(i), 0, 0); cycle();
        end
        cdb(0, 32'h200, 0, 0); cycle();
        idle();
        for (int i = 0; i < 20; i++) cycle();

        // Mispredicted branch at id 2 flushes younger ready entries
        do_reset();
        issue(ROB_TYPE_REG, 5'd1); cycle();
        issue(ROB_TYPE_REG, 5'd2); cycle();
        issue(ROB_TYPE_BRANCH, 5'd0); cycle();
        issue(ROB_TYPE_REG, 5'd3); cycle();
        issue(ROB_TYPE_STORE, 5'd4); cycle();
        idle(); cdb(4, 32'h44, 0, 0); cycle();
        cdb(3, 32'h33, 0, 0); cycle();
        cdb(2, 32'h0, 1, 32'h80); cycle();
        cdb(0, 32'h10, 0, 0); cycle();
        cdb(1, 32'h11, 0, 0); cycle();
        issue(ROB_TYPE_REG, 5'd9); cdb(3, 32'h55, 0, 0); cycle();
        cycle();
        check("t4_flushOut", 32'(flushOut), 32'd1);
        check("t4_flushPc", flushPc, 32'h80);
        idle();
        for (int i = 0; i < 3; i++) cycle();
        #1;
        check("t4_addId", 32'(robAddId), 32'd0);
        check("t4_empty_not_full", 32'(robFull), 32'd0);

        // Operand query against a result arriving this cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(ROB_TYPE_REG, 5'(i + 8)); cycle();
        end
        idle(); robRs1Dep = 4'd3; robRs2Dep = 4'd1; cdb(3, 32'hAB, 0, 0); cycle();
        idle(); cycle();
        robRs1Dep = 4'd3; #1;
        check("t5_next_ready", 32'(robRs1Ready), 32'd1);
        check("t5_next_value", robRs1Value, 32'hAB);
        #1;

        // Random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            robAddValid = ($urandom_range(0, 9) < 6);
            robAddType  = 2'($urandom_range(0, 3));
            robAddDest  = 5'($urandom_range(0, 31));
            cdbValid    = ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                cdbRobId = W'(q[$urandom_range(0, q.size() - 1)].id);
            else
                cdbRobId = W'($urandom_range(0, D - 1));
            cdbValue      = $urandom;
            cdbMispredict = ($urandom_range(0, 7) == 0);
            cdbTarget     = $urandom;
            robRs1Dep     = W'($urandom_range(0, D - 1));
            robRs2Dep     = W'($urandom_range(0, D - 1));
            cycle();
        end

        // Asynchronous reset in the middle of traffic
        do_reset();
        idle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
